mem_stage_wait: RTL and testbench

Parametrised data-memory stage for the 5-stage pipeline, successor to the single-cycle MEM stage. Word-addressed data RAM with a configurable base address, depth and access latency. Each load/store is serviced by a small FSM, and a `ready` handshake freezes the upstream pipeline while an access is in flight. Out-of-range accesses are flagged, not silently aliased.

---
 rtl/mem_stage_wait.sv | 133 +++++++++++++
 tb/tb_mem_stage_wait.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_wait.sv
// Data-memory stage with multi-cycle access FSM and ready handshake.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned byte addresses are treated as invalid.
module mem_stage_wait #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEMread,
  input  logic              MEMwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] MEM_result,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH * 4);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              wr_reg, rd_reg, valid_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] result_reg;
  logic              err_reg;
  logic [DATA_W-1:0] ram [DEPTH];

  logic              req, in_wr, in_rd, in_valid;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  in_idx;

  assign req    = MEMread | MEMwrite;
  assign in_wr  = MEMwrite;
  assign in_rd  = MEMread & ~MEMwrite;
  assign offset = address - BASE;
  assign in_idx = offset[IDX_W+1:2];

  // Range test uses the unwrapped comparison so addresses below BASE never alias.
  always_comb begin
    in_valid = (address >= BASE) && (offset < SPAN);
`ifdef MEM_ALIGN_CHECK_EN
    if (address[1:0] != 2'b00) in_valid = 1'b0;
`endif
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = ~req;
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait cycles the commit happens straight from IDLE, so use live inputs there.
  logic              commit, c_wr, c_rd, c_valid;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_data;

  always_comb begin
    commit  = (state_next == DONE) && (state_reg != DONE);
    c_wr    = (state_reg == IDLE) ? in_wr    : wr_reg;
    c_rd    = (state_reg == IDLE) ? in_rd    : rd_reg;
    c_valid = (state_reg == IDLE) ? in_valid : valid_reg;
    c_idx   = (state_reg == IDLE) ? in_idx   : idx_reg;
    c_data  = (state_reg == IDLE) ? data     : data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      wr_reg     <= 1'b0;
      rd_reg     <= 1'b0;
      valid_reg  <= 1'b0;
      idx_reg    <= '0;
      data_reg   <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req) begin
        wr_reg    <= in_wr;
        rd_reg    <= in_rd;
        valid_reg <= in_valid;
        idx_reg   <= in_idx;
        data_reg  <= data;
      end
      err_reg <= 1'b0;
      if (commit) begin
        err_reg <= ~c_valid;
        if (c_wr && c_valid) ram[c_idx] <= c_data;
        if (c_rd) result_reg <= c_valid ? ram[c_idx] : '0;
      end
    end
  end

  assign MEM_result = result_reg;
  assign addr_err   = err_reg;

endmodule

// File: tb/tb_mem_stage_wait.sv
// Directed bench for mem_stage_wait with a scoreboard queue and a small RAM model.
// Honours MEM_ALIGN_CHECK_EN in its expectations when defined.
module tb_mem_stage_wait;

  localparam int WAIT_CYCLES = 2;
  localparam int DEPTH       = 64;
  localparam logic [31:0] BASE = 32'd1024;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEMread, MEMwrite;
  logic [31:0] address, data;
  logic [31:0] MEM_result;
  logic        ready, addr_err;

  int compared   = 0;
  int mismatched = 0;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_res;

  mem_stage_wait dut (
    .clk(clk), .rst(rst), .MEMread(MEMread), .MEMwrite(MEMwrite),
    .address(address), .data(data), .MEM_result(MEM_result),
    .ready(ready), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_res = '0;
  endtask

  // One access: push expectation, drive at T, drop inputs, wait for ready, pop and compare.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] off;
    bit          valid;
    int          idx, k;
    off   = addr - BASE;
    valid = (addr >= BASE) && (off < 32'(DEPTH * 4));
`ifdef MEM_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) valid = 1'b0;
`endif
    idx   = int'(off >> 2);
    e.tag = tag;
    e.err = ~valid;
    if (wr) begin
      e.res = last_res;
      if (valid) model[idx] = wdata;
    end else begin
      e.res    = valid ? model[idx] : 32'h0;
      last_res = e.res;
    end
    sb.push_back(e);

    @(negedge clk);
    MEMread = rd; MEMwrite = wr; address = addr; data = wdata;
    #1 check({tag, ".ready_T"}, {31'b0, ready}, 32'd0);
    @(negedge clk);
    MEMread = 1'b0; MEMwrite = 1'b0; address = $urandom; data = $urandom;
    k = 1;
    while (!ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 32'(k), 32'(WAIT_CYCLES + 1));
    if (sb.size() == 0) begin
      compared++; mismatched++;
      $error("FAIL %s.scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".result"}, MEM_result, e.res);
      check({e.tag, ".err"}, {31'b0, addr_err}, {31'b0, e.err});
      $display("%s rd=%0b wr=%0b addr=%0d data=%h -> result=%h err=%0b", tag, rd, wr, addr, wdata, MEM_result, addr_err);
    end
  endtask

  initial begin
    rst = 1'b1; MEMread = 1'b0; MEMwrite = 1'b0; address = '0; data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.ready", {31'b0, ready}, 32'd1);
    check("reset.result", MEM_result, 32'h0);
    check("reset.err", {31'b0, addr_err}, 32'd0);

    // 1. read after reset
    access("rd1024_init", 1'b1, 1'b0, 32'd1024, 32'h0);
    // 2. write then read back
    access("wr1028", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    access("rd1028", 1'b1, 1'b0, 32'd1028, 32'h0);
    check("rd1028.const", MEM_result, 32'hDEADBEEF);
    // 3. back-to-back stores at both ends, reads, neighbours untouched
    access("wr1024", 1'b0, 1'b1, 32'd1024, 32'h11);
    access("wr1276", 1'b0, 1'b1, 32'd1276, 32'h3F);
    access("rd1024", 1'b1, 1'b0, 32'd1024, 32'h0);
    check("rd1024.const", MEM_result, 32'h11);
    access("rd1276", 1'b1, 1'b0, 32'd1276, 32'h0);
    check("rd1276.const", MEM_result, 32'h3F);
    access("rd1272", 1'b1, 1'b0, 32'd1272, 32'h0);
    access("rd1028b", 1'b1, 1'b0, 32'd1028, 32'h0);
    // 4. out-of-range accesses
    access("wr1280_oob", 1'b0, 1'b1, 32'd1280, 32'h12345678);
    access("rd1020_oob", 1'b1, 1'b0, 32'd1020, 32'h0);
    access("rd0_oob", 1'b1, 1'b0, 32'd0, 32'h0);
    access("rd1276c", 1'b1, 1'b0, 32'd1276, 32'h0);
    access("rd1026_align", 1'b1, 1'b0, 32'd1026, 32'h0);

    // 5. reset in the middle of a write aborts it and clears RAM
    @(negedge clk);
    MEMread = 1'b0; MEMwrite = 1'b1; address = 32'd1032; data = 32'hA5A5A5A5;
    #1 check("abort.ready_T", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1; MEMwrite = 1'b0; address = '0; data = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("abort.ready", {31'b0, ready}, 32'd1);
    check("abort.result", MEM_result, 32'h0);
    check("abort.err", {31'b0, addr_err}, 32'd0);
    $display("abort: reset asserted at T+1 of write 1032");
    access("rd1032_after", 1'b1, 1'b0, 32'd1032, 32'h0);
    check("rd1032.const", MEM_result, 32'h0);
    access("rd1028_after", 1'b1, 1'b0, 32'd1028, 32'h0);

    // 6. read+write together behaves as a write and keeps MEM_result
    access("wr1040", 1'b0, 1'b1, 32'd1040, 32'h5);
    access("rd1040", 1'b1, 1'b0, 32'd1040, 32'h0);
    access("rdwr1036", 1'b1, 1'b1, 32'd1036, 32'h77);
    check("rdwr1036.const", MEM_result, 32'h5);
    access("rd1036", 1'b1, 1'b0, 32'd1036, 32'h0);
    check("rd1036.const", MEM_result, 32'h77);

    // a few random in-range word accesses
    for (int n = 0; n < 6; n++) begin
      logic [31:0] a, d;
      a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      d = $urandom;
      access("rand_wr", 1'b0, 1'b1, a, d);
      access("rand_rd", 1'b1, 1'b0, a, 32'h0);
    end

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
